// File: rtl/x25519_operand_loader_if.sv
// Byte-stream and multiplier handshake bundle between the operand loader and its neighbours.
// The loader takes the slave side; the byte source / multiplier side takes the master side.
interface x25519_operand_loader_if;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [254:0] k;
  logic [254:0] x_p;
  logic         mult_rst;
  logic         mult_done;
  logic         busy;

  modport master (
    output in_valid, in_data, mult_done,
    input  in_ready, k, x_p, mult_rst, busy
  );

  modport slave (
    input  in_valid, in_data, mult_done,
    output in_ready, k, x_p, mult_rst, busy
  );
endinterface

// File: rtl/x25519_operand_loader.sv
// Collects a 64-byte scalar/u stream, clamps the scalar, reduces u mod 2^255-19,
// and sequences the multiplier reset around each operation.
//
// state  | meaning
// LOAD_K | accepting scalar bytes 0..31
// LOAD_U | accepting u bytes 32..63
// PREP   | register clamped k and reduced x_p
// HOLD   | keep multiplier in reset for HOLD_CYCLES cycles
// RUN    | multiplier running, wait for mult_done
module x25519_operand_loader #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst,
  x25519_operand_loader_if.slave bus
);

  typedef enum logic [2:0] {
    LOAD_K = 3'd0,
    LOAD_U = 3'd1,
    PREP   = 3'd2,
    HOLD   = 3'd3,
    RUN    = 3'd4
  } state_t;

  localparam logic [3:0]   HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
  localparam logic [255:0] P_MOD      = {1'b0, {247{1'b1}}, 8'hED};
  localparam logic [255:0] LOW255     = {1'b0, {255{1'b1}}};
  localparam logic [255:0] CLAMP_AND  = {2'b01, {251{1'b1}}, 3'b000};
  localparam logic [255:0] CLAMP_OR   = {2'b01, 254'd0};

  state_t       state;
  state_t       state_next;
  logic [5:0]   byte_cnt;
  logic [3:0]   hold_cnt;
  logic [255:0] scalar_buf;
  logic [255:0] u_buf;
  logic [254:0] k_q;
  logic [254:0] x_p_q;
  logic         busy_q;
  logic         ready;
  logic         mult_rst_c;
  logic         accept;
  logic         hold_tc;
  logic [255:0] u_diff;
  logic [254:0] k_next;
  logic [254:0] x_p_next;

  assign accept  = bus.in_valid && ready;
  assign hold_tc = (hold_cnt == 4'd0);

  // Single 256-bit subtract: a borrow into bit 255 means u' < p and u' is kept as is.
  assign u_diff   = (u_buf & LOW255) - P_MOD;
  assign x_p_next = u_diff[255] ? 255'(u_buf) : u_diff[254:0];
  assign k_next   = 255'((scalar_buf & CLAMP_AND) | CLAMP_OR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_K;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD_K:  if (accept && byte_cnt == 6'd31) state_next = LOAD_U;
      LOAD_U:  if (accept && byte_cnt == 6'd63) state_next = PREP;
      PREP:    state_next = HOLD;
      HOLD:    if (hold_tc) state_next = RUN;
      RUN:     if (bus.mult_done) state_next = LOAD_K;
      default: state_next = LOAD_K;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    mult_rst_c = 1'b1;
    unique case (state)
      LOAD_K:  ready = !rst;
      LOAD_U:  ready = !rst;
      PREP:    ready = 1'b0;
      HOLD:    ready = 1'b0;
      RUN:     mult_rst_c = rst;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 6'd0;
      hold_cnt   <= 4'd0;
      scalar_buf <= '0;
      u_buf      <= '0;
      k_q        <= '0;
      x_p_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 6'd1;
        busy_q   <= 1'b1;
        // Shifting in at the top leaves byte 0 in bits 7:0 after 32 bytes.
        if (state == LOAD_K) begin
          scalar_buf <= {bus.in_data, scalar_buf[255:8]};
        end else begin
          u_buf <= {bus.in_data, u_buf[255:8]};
        end
      end
      if (state == PREP) begin
        k_q      <= k_next;
        x_p_q    <= x_p_next;
        hold_cnt <= HOLD_LOAD;
      end
      if (state == HOLD && !hold_tc) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
      if (state == RUN && bus.mult_done) begin
        busy_q   <= 1'b0;
        byte_cnt <= 6'd0;
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.mult_rst = mult_rst_c;
  assign bus.k        = k_q;
  assign bus.x_p      = x_p_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_x25519_operand_loader.sv
// Randomized and directed bench for the X25519 operand loader against an arithmetic model.
module tb_x25519_operand_loader;

  localparam int HOLD = 3;
  localparam logic [255:0] TWO254 = 256'd1 << 254;
  localparam logic [255:0] TWO255 = 256'd1 << 255;
  localparam logic [255:0] P      = TWO255 - 256'd19;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  x25519_operand_loader_if bus();

  x25519_operand_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [254:0] model_k(input logic [255:0] a);
    logic [255:0] c;
    c = a - (a % 256'd8);
    if (c >= TWO255) c = c - TWO255;
    if (c < TWO254) c = c + TWO254;
    return c[254:0];
  endfunction

  function automatic logic [254:0] model_x(input logic [255:0] u);
    logic [255:0] v;
    v = u;
    if (v >= TWO255) v = v - TWO255;
    if (v >= P) v = v - P;
    return v[254:0];
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic feed_bytes(input logic [511:0] data, input int n, input bit gaps, input string name);
    int idx = 0;
    int guard = 0;
    bit rdy;
    while (idx < n && guard < 2000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = data[8*idx +: 8];
      end
      #1 rdy = bus.in_ready;
      @(posedge clk);
      if (rdy && bus.in_valid) idx++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL %s feed: accepted %0d bytes, required %0d", name, idx, n);
    end
  endtask

  task automatic run_op(input logic [511:0] data, input logic [254:0] ek, input logic [254:0] ex,
                        input bit gaps, input bit done_in_hold, input string name);
    int  n = 0;
    int  wait_cycles;
    bit  ready_low = 1'b1;
    bit  run_ok = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: busy=%b in_ready=%b, required busy=0 in_ready=1", name, bus.busy, bus.in_ready);
    end
    feed_bytes(data, 64, gaps, name);
    while (bus.mult_rst === 1'b1 && n < 40) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'($urandom);
      bus.mult_done = done_in_hold && (n == 1);
      #1 if (bus.in_ready !== 1'b0) ready_low = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.mult_done = 1'b0;
    checks++;
    if (!ready_low) begin
      errors++;
      $display("FAIL %s in_ready in PREP/HOLD: got 1, required 0", name);
    end
    checks++;
    if (n != HOLD + 1) begin
      errors++;
      $display("FAIL %s mult_rst latency: got %0d cycles, required %0d", name, n, HOLD + 1);
    end
    checks++;
    if (bus.k !== ek) begin
      errors++;
      $display("FAIL %s k: got %h required %h", name, bus.k, ek);
    end
    checks++;
    if (bus.x_p !== ex) begin
      errors++;
      $display("FAIL %s x_p: got %h required %h", name, bus.x_p, ex);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy in RUN: got %b required 1", name, bus.busy);
    end
    wait_cycles = $urandom_range(0, 4);
    for (int i = 0; i < wait_cycles; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      #1 if (bus.mult_rst !== 1'b0 || bus.in_ready !== 1'b0) run_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.mult_done = 1'b1;
    #1 if (bus.mult_rst !== 1'b0 || bus.in_ready !== 1'b0) run_ok = 1'b0;
    checks++;
    if (!run_ok) begin
      errors++;
      $display("FAIL %s RUN outputs: mult_rst/in_ready not held at 0/0", name);
    end
    @(posedge clk);
    @(negedge clk);
    bus.mult_done = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mult_rst !== 1'b1) begin
      errors++;
      $display("FAIL %s after done: in_ready=%b busy=%b mult_rst=%b, required 1 0 1",
               name, bus.in_ready, bus.busy, bus.mult_rst);
    end
    checks++;
    if (bus.k !== ek || bus.x_p !== ex) begin
      errors++;
      $display("FAIL %s operand hold: k=%h x_p=%h changed after done", name, bus.k, bus.x_p);
    end
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mult_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.mult_rst !== 1'b1 || bus.busy !== 1'b0 ||
        bus.k !== 255'd0 || bus.x_p !== 255'd0) begin
      errors++;
      $display("FAIL %s during rst: in_ready=%b mult_rst=%b busy=%b k=%h x_p=%h, required 0 1 0 0 0",
               name, bus.in_ready, bus.mult_rst, bus.busy, bus.k, bus.x_p);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s first cycle after rst: in_ready=%b required 1", name, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    bus.in_data = 8'h00;
    pulse_reset("reset");
  endtask

  task automatic test_base();
    logic [511:0] d = '0;
    d[263:256] = 8'h09;
    run_op(d, TWO254[254:0], 255'd9, 1'b0, 1'b0, "base");
  endtask

  task automatic test_saturation();
    logic [511:0] d = '1;
    logic [255:0] ek = TWO255 - 256'd8;
    run_op(d, ek[254:0], 255'd18, 1'b0, 1'b0, "saturation");
  endtask

  task automatic test_u_boundary();
    logic [511:0] d = '0;
    logic [255:0] pm1 = P - 256'd1;
    logic [255:0] ex = TWO255 - 256'd20;
    d[511:256] = P;
    run_op(d, TWO254[254:0], 255'd0, 1'b0, 1'b0, "u_eq_p");
    d[511:256] = pm1;
    run_op(d, TWO254[254:0], ex[254:0], 1'b0, 1'b0, "u_p_minus_1");
    d[511:256] = TWO255 + 256'd9;
    run_op(d, TWO254[254:0], 255'd9, 1'b0, 1'b0, "u_bit255");
  endtask

  task automatic test_backpressure();
    logic [511:0] d = rand_data();
    run_op(d, model_k(d[255:0]), model_x(d[511:256]), 1'b0, 1'b0, "contiguous");
    run_op(d, model_k(d[255:0]), model_x(d[511:256]), 1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_random();
    logic [511:0] d;
    for (int i = 0; i < 6; i++) begin
      d = rand_data();
      if (i % 2 == 1) begin
        d[511:256] = P + 256'($urandom_range(0, 18));
        if ($urandom_range(0, 1) == 1) d[511:256] = d[511:256] + TWO255;
      end
      run_op(d, model_k(d[255:0]), model_x(d[511:256]), 1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  task automatic test_reset_midload();
    logic [511:0] d1 = rand_data();
    logic [511:0] d2 = rand_data();
    feed_bytes(d1, 40, 1'b1, "midload_partial");
    pulse_reset("midload_reset");
    run_op(d2, model_k(d2[255:0]), model_x(d2[511:256]), 1'b0, 1'b0, "after_midload_reset");
  endtask

  task automatic test_done_during_hold();
    logic [511:0] d = rand_data();
    run_op(d, model_k(d[255:0]), model_x(d[511:256]), 1'b0, 1'b1, "done_in_hold");
  endtask

  task automatic test_reset_in_run();
    logic [511:0] d1 = rand_data();
    logic [511:0] d2 = rand_data();
    int n = 0;
    feed_bytes(d1, 64, 1'b0, "run_partial");
    while (bus.mult_rst === 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.mult_rst !== 1'b0) begin
      errors++;
      $display("FAIL reach_run: mult_rst=%b after %0d cycles, required 0", bus.mult_rst, n);
    end
    pulse_reset("run_reset");
    run_op(d2, model_k(d2[255:0]), model_x(d2[511:256]), 1'b1, 1'b0, "after_run_reset");
  endtask

  task automatic test_back_to_back();
    logic [511:0] d1 = '0;
    logic [511:0] d2 = rand_data();
    d1[255:0]   = rand_data();
    d1[263:256] = 8'h09;
    run_op(d1, model_k(d1[255:0]), 255'd9, 1'b0, 1'b0, "e2e_first");
    run_op(d2, model_k(d2[255:0]), model_x(d2[511:256]), 1'b0, 1'b0, "e2e_second");
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.mult_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_base();
    test_saturation();
    test_u_boundary();
    test_backpressure();
    test_random();
    test_reset_midload();
    test_done_during_hold();
    test_reset_in_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/x25519_operand_loader.md
X25519_OPERAND_LOADER -- requirements
Module: x25519_operand_loader

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: number of cycles mult_rst stays high after operands are registered (range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  byte-stream valid.
REQ-005 SHALL have port in_data  input  8  operand byte.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port k  output  255  clamped scalar to the multiplier.
REQ-008 SHALL have port x_p  output  255  reduced u-coordinate to the multiplier.
REQ-009 SHALL have port mult_rst  output  1  multiplier reset; the multiplier starts on its falling edge.
REQ-010 SHALL have port mult_done  input  1  multiplier done flag.
REQ-011 SHALL have port busy  output  1  high from the first accepted byte until mult_done is seen.

Function
REQ-012 SHALL accept a byte only on cycles with in_valid && in_ready; idle cycles with in_valid low SHALL not advance the state.
REQ-013 SHALL take 64 bytes per operation: bytes 0-31 are the scalar, little-endian (byte 0 = bits 7:0); bytes 32-63 are u, little-endian.
REQ-014 SHALL use 6-bit byte counter 0..63, cleared on entry to LOAD_K.
REQ-015 SHALL use states LOAD_K, LOAD_U, PREP, HOLD, RUN.
REQ-016 LOAD_K: in_ready=1; after byte 31 is accepted, goes to LOAD_U.
REQ-017 LOAD_U: in_ready=1; after byte 63 is accepted, goes to PREP.
REQ-018 PREP (1 cycle): in_ready=0; registers k and x_p; goes to HOLD.
REQ-019 HOLD: in_ready=0; stays HOLD_CYCLES cycles, then goes to RUN.
REQ-020 RUN: in_ready=0, mult_rst=0; waits for mult_done=1, then goes to LOAD_K in the next cycle.
REQ-021 mult_rst SHALL be 1 in every state except RUN, so the multiplier never sees operands change while running.
REQ-022 Scalar clamp: on the 256-bit scalar a, clear bits 2:0 and bit 255 and set bit 254; k = clamped a[254:0].
REQ-023 u reduction: clear bit 255 to get u' < 2^255; if u' >= p (p = 2^255-19), x_p = u' - p (range 0..18); otherwise x_p = u'.
REQ-024 The reduction SHALL use one 256-bit subtract or compare in PREP, with no multi-cycle arithmetic.
REQ-025 k and x_p SHALL hold their values from PREP until the next PREP.
REQ-026 mult_done SHALL be ignored in every state except RUN.
REQ-027 in_data SHALL be ignored when in_ready=0.

Reset
REQ-028 While rst=1: state goes to LOAD_K; counter=0; k=0; x_p=0; mult_rst=1; in_ready=0; busy=0.
REQ-029 In the first cycle after rst falls: in_ready=1.
REQ-030 rst asserted in any state, including mid-load or RUN, SHALL discard all partial bytes; the next operation starts at byte 0.

Verification
REQ-031 Base case: scalar bytes 0x00 x32, u bytes {0x09, 0x00 x31} -> k = 2^254, x_p = 9, mult_rst falls exactly HOLD_CYCLES+1 cycles after byte 63 is accepted.
REQ-032 Saturation: scalar 0xFF x32, u 0xFF x32 -> k = 2^255-8, x_p = 18.
REQ-033 u boundary: u = p (bytes ED, FF x30, 7F) -> x_p = 0; u = p-1 (EC, FF x30, 7F) -> x_p = 2^255-20; bit 255 set on u = 9 (09, 00 x30, 80) -> x_p = 9.
REQ-034 Backpressure: in_valid toggled randomly across 64 bytes -> same k and x_p as contiguous feed; in_ready=0 from PREP until 1 cycle after mult_done.
REQ-035 Reset after 40 bytes, then a full 64-byte stream -> outputs reflect only the second stream; mult_done pulsed during HOLD -> no state change.
REQ-036 End-to-end with scalar_multiplication: u = 9, scalar bytes giving clamped k -> mult_rst falls once, busy drops after done, and a second back-to-back operation starts with in_ready=1.
